// File: rtl/predict_pkg.sv
// predict_pkg: shared constants, FSM state type and saturation helper for the
// 15-10-2 fixed-point (Q15.16) classifier engine.
package predict_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned FRAC  = 16;
    localparam int unsigned ROWS  = 100;
    localparam int unsigned FEAT  = 15;
    localparam int unsigned HID   = 10;
    localparam int unsigned OUTS  = 2;
    localparam int unsigned ACC_W = 2 * WIDTH;

    // ROM layout: each data row and each hidden neuron occupy 16 words,
    // output neurons follow the hidden block at 11 words each.
    localparam int unsigned DATA_STRIDE = 16;
    localparam int unsigned HID_STRIDE  = 16;
    localparam int unsigned OUT_BASE    = 160;
    localparam int unsigned OUT_STRIDE  = 11;

    localparam int unsigned DATA_WORDS = ROWS * DATA_STRIDE;
    localparam int unsigned WGT_WORDS  = OUT_BASE + OUTS * OUT_STRIDE;
    localparam int unsigned DATA_AW    = $clog2(DATA_WORDS);
    localparam int unsigned WGT_AW     = $clog2(WGT_WORDS);
    localparam int unsigned ROW_W      = $clog2(ROWS);
    localparam int unsigned IDX_W      = $clog2(FEAT);
    localparam int unsigned HID_W      = $clog2(HID);
    localparam int unsigned OUT_W      = (OUTS > 1) ? $clog2(OUTS) : 1;
    localparam int unsigned CNT_W      = $clog2(ROWS + 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StHidMac,
        StHidAct,
        StOutMac,
        StOutAct,
        StCompare,
        StDone
    } state_t;

    // Clamp a wide accumulator value into the signed WIDTH range.
    function automatic logic signed [WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            saturate = {1'b0, {(WIDTH - 1){1'b1}}};
        end else if (v < SAT_MIN) begin
            saturate = {1'b1, {(WIDTH - 1){1'b0}}};
        end else begin
            saturate = v[WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/predict_mac.sv
// predict_mac: signed Q15.16 multiply-accumulate.
//   clk, rst_n : clock, async active-low reset
//   i_clr      : clear accumulator (wins over i_acc)
//   i_acc      : add (i_a * i_b) >>> FRAC to accumulator
//   i_a, i_b   : signed operands
//   i_bias     : bias added combinationally to the accumulator for o_sat
//   o_sat      : saturate(acc + bias)
module predict_mac
    import predict_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_acc,
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    input  logic signed [WIDTH-1:0] i_bias,
    output logic signed [WIDTH-1:0] o_sat
);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_a_ext;
    logic signed [ACC_W-1:0] w_b_ext;
    logic signed [ACC_W-1:0] w_bias_ext;
    logic signed [ACC_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_sum;

    assign w_a_ext    = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_b_ext    = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_bias_ext = {{WIDTH{i_bias[WIDTH-1]}}, i_bias};

    // Full 32x32 product fits in 64 bits; shift drops the extra fraction bits.
    assign w_prod = (w_a_ext * w_b_ext) >>> FRAC;
    assign w_sum  = r_acc + w_bias_ext;
    assign o_sat  = saturate(w_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_acc) begin
            r_acc <= r_acc + w_prod;
        end
    end

endmodule

// File: rtl/predict.sv
// predict: classifies every test row with a 15-10-2 fixed-point network held in
// ROM and counts correct predictions.
//   clk         : rising-edge clock
//   rst_n       : async active-low reset; restarts the run from row 0
//   acc_cal     : high once all rows are evaluated, sticky until reset
//   correct_cnt : number of correctly classified rows
module predict
    import predict_pkg::*;
#(
    parameter string DATA_FILE   = "test_dataset.hex",
    parameter string WEIGHT_FILE = "weights_1.hex"
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             acc_cal,
    output logic [CNT_W-1:0] correct_cnt
);

    logic [WIDTH-1:0] r_data_rom [DATA_WORDS];
    logic [WIDTH-1:0] r_wgt_rom  [WGT_WORDS];

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ROW_W-1:0]        r_row;
    logic [IDX_W-1:0]        r_j;
    logic [HID_W-1:0]        r_n;
    logic [OUT_W-1:0]        r_c;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [WIDTH-1:0] r_h     [HID];
    logic signed [WIDTH-1:0] r_logit [OUTS];

    logic [DATA_AW-1:0]      w_dat_addr;
    logic [WGT_AW-1:0]       w_wgt_addr;
    logic signed [WIDTH-1:0] w_dat;
    logic signed [WIDTH-1:0] w_wgt;
    logic signed [WIDTH-1:0] w_mac_a;
    logic signed [WIDTH-1:0] w_mac_sat;
    logic signed [WIDTH-1:0] w_relu;
    logic                    w_mac_acc;
    logic                    w_mac_clr;
    logic                    w_j_last;
    logic                    w_pred;
    logic                    w_label;

    // Combinational ROM reads keep every MAC step to exactly one cycle.
    always_comb begin
        w_dat_addr = DATA_AW'(DATA_STRIDE * 32'(r_row) + 32'(r_j));
        if (r_state == StCompare) begin
            w_dat_addr = DATA_AW'(DATA_STRIDE * 32'(r_row) + FEAT);
        end
        w_wgt_addr = '0;
        case (r_state)
            StHidMac: w_wgt_addr = WGT_AW'(HID_STRIDE * 32'(r_n) + 32'(r_j));
            StHidAct: w_wgt_addr = WGT_AW'(HID_STRIDE * 32'(r_n) + FEAT);
            StOutMac: w_wgt_addr = WGT_AW'(OUT_BASE + OUT_STRIDE * 32'(r_c) + 32'(r_j));
            StOutAct: w_wgt_addr = WGT_AW'(OUT_BASE + OUT_STRIDE * 32'(r_c) + HID);
            default:  w_wgt_addr = '0;
        endcase
    end

    assign w_dat   = r_data_rom[w_dat_addr];
    assign w_wgt   = r_wgt_rom[w_wgt_addr];
    assign w_mac_a = (r_state == StHidMac) ? w_dat : r_h[r_j];
    assign w_relu  = w_mac_sat[WIDTH-1] ? '0 : w_mac_sat;
    // Tie resolves to class 0.
    assign w_pred  = (r_logit[1] > r_logit[0]);
    assign w_label = (w_dat != '0);

    // In the ACT states the weight address points at the bias word.
    predict_mac u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_mac_clr),
        .i_acc  (w_mac_acc),
        .i_a    (w_mac_a),
        .i_b    (w_wgt),
        .i_bias (w_wgt),
        .o_sat  (w_mac_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mac_acc    = 1'b0;
        w_mac_clr    = 1'b0;
        w_j_last     = (r_state == StHidMac) ? (r_j == IDX_W'(FEAT - 1))
                                             : (r_j == IDX_W'(HID - 1));
        case (r_state)
            StIdle: w_state_next = StHidMac;
            StHidMac: begin
                w_mac_acc = 1'b1;
                if (w_j_last) w_state_next = StHidAct;
            end
            StHidAct: begin
                w_mac_clr    = 1'b1;
                w_state_next = (r_n == HID_W'(HID - 1)) ? StOutMac : StHidMac;
            end
            StOutMac: begin
                w_mac_acc = 1'b1;
                if (w_j_last) w_state_next = StOutAct;
            end
            StOutAct: begin
                w_mac_clr    = 1'b1;
                w_state_next = (r_c == OUT_W'(OUTS - 1)) ? StCompare : StOutMac;
            end
            StCompare: w_state_next = (r_row == ROW_W'(ROWS - 1)) ? StDone : StHidMac;
            StDone:    w_state_next = StDone;
            default:   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_j   <= '0;
            r_n   <= '0;
            r_c   <= '0;
            r_cnt <= '0;
            for (int i = 0; i < HID; i++) r_h[i] <= '0;
            for (int i = 0; i < OUTS; i++) r_logit[i] <= '0;
        end else begin
            case (r_state)
                StHidMac, StOutMac: begin
                    r_j <= w_j_last ? '0 : r_j + IDX_W'(1);
                end
                StHidAct: begin
                    r_h[r_n] <= w_relu;
                    r_n      <= (r_n == HID_W'(HID - 1)) ? '0 : r_n + HID_W'(1);
                end
                StOutAct: begin
                    r_logit[r_c] <= w_mac_sat;
                    r_c          <= (r_c == OUT_W'(OUTS - 1)) ? '0 : r_c + OUT_W'(1);
                end
                StCompare: begin
                    if (w_pred == w_label) r_cnt <= r_cnt + CNT_W'(1);
                    if (r_row != ROW_W'(ROWS - 1)) r_row <= r_row + ROW_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign acc_cal     = (r_state == StDone);
    assign correct_cnt = r_cnt;

endmodule

// File: tb/tb_predict.sv
// tb_predict: directed bench for predict. ROM contents are written directly into
// the DUT arrays while reset is held, then the run is timed edge by edge.
module tb_predict;

    localparam int LAST_EDGE = 18301;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       acc_cal;
    logic [6:0] correct_cnt;

    int errors = 0;
    int checks = 0;

    predict #(
        .DATA_FILE   (""),
        .WEIGHT_FILE ("")
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .acc_cal     (acc_cal),
        .correct_cnt (correct_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Counts rising edges since release until acc_cal is seen, bounded.
    task automatic run_to_done(output int edges);
        edges = 0;
        while (acc_cal !== 1'b1 && edges < 20000) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic fill_roms(input logic [31:0] dval, input logic [31:0] wval);
        for (int i = 0; i < 1600; i++) dut.r_data_rom[i] = dval;
        for (int i = 0; i < 182; i++) dut.r_wgt_rom[i] = wval;
    endtask

    // w[0][0]=1.0, v[1][0]=1.0. Row pattern (r % 5):
    //   0: f0=+2.0 lbl 1 -> right   1: f0=-2.0 lbl 0 -> right (ReLU, tie)
    //   2: f0=+2.0 lbl 0 -> wrong   3: f0=0    lbl 7 -> wrong (tie gives 0)
    //   4: f0=+0.5 lbl 1 -> right   => 60 of 100
    task automatic load_mixed();
        logic [31:0] f;
        logic [31:0] l;
        fill_roms(32'h0, 32'h0);
        dut.r_wgt_rom[0]   = 32'h0001_0000;
        dut.r_wgt_rom[171] = 32'h0001_0000;
        for (int r = 0; r < 100; r++) begin
            case (r % 5)
                0:       begin f = 32'h0002_0000; l = 32'd1; end
                1:       begin f = 32'hFFFE_0000; l = 32'd0; end
                2:       begin f = 32'h0002_0000; l = 32'd0; end
                3:       begin f = 32'h0000_0000; l = 32'd7; end
                default: begin f = 32'h0000_8000; l = 32'd1; end
            endcase
            dut.r_data_rom[r*16]      = f;
            dut.r_data_rom[r*16 + 15] = l;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (acc_cal !== 1'b0) begin
            errors++;
            $display("FAIL reset_acc_cal: got %b expected 0", acc_cal);
        end
        checks++;
        if (correct_cnt !== 7'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", correct_cnt);
        end
    endtask

    task automatic test_zero_weights();
        int edges;
        hold_reset();
        fill_roms(32'h0, 32'h0);
        release_reset();
        run_to_done(edges);
        checks++;
        if (edges !== LAST_EDGE) begin
            errors++;
            $display("FAIL zero_done_edge: got %0d expected %0d", edges, LAST_EDGE);
        end
        checks++;
        if (correct_cnt !== 7'd100) begin
            errors++;
            $display("FAIL zero_count: got %0d expected 100", correct_cnt);
        end
    endtask

    task automatic test_forward_mixed();
        int edges;
        int bad;
        hold_reset();
        load_mixed();
        release_reset();
        run_to_done(edges);
        checks++;
        if (edges !== LAST_EDGE) begin
            errors++;
            $display("FAIL mixed_done_edge: got %0d expected %0d", edges, LAST_EDGE);
        end
        checks++;
        if (correct_cnt !== 7'd60) begin
            errors++;
            $display("FAIL mixed_count: got %0d expected 60", correct_cnt);
        end
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            if (acc_cal !== 1'b1 || correct_cnt !== 7'd60) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL done_sticky: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_run();
        int edges;
        hold_reset();
        load_mixed();
        release_reset();
        step(5000);
        // Rows 0..26 have finished by edge 5000: 17 of them are right.
        checks++;
        if (correct_cnt !== 7'd17) begin
            errors++;
            $display("FAIL midrun_partial_count: got %0d expected 17", correct_cnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (acc_cal !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset_acc_cal: got %b expected 0", acc_cal);
        end
        checks++;
        if (correct_cnt !== 7'd0) begin
            errors++;
            $display("FAIL midrun_reset_count: got %0d expected 0", correct_cnt);
        end
        step(10);
        rst_n = 1'b1;
        run_to_done(edges);
        checks++;
        if (edges !== LAST_EDGE) begin
            errors++;
            $display("FAIL midrun_done_edge: got %0d expected %0d", edges, LAST_EDGE);
        end
        checks++;
        if (correct_cnt !== 7'd60) begin
            errors++;
            $display("FAIL midrun_count: got %0d expected 60", correct_cnt);
        end
    endtask

    task automatic test_saturation();
        hold_reset();
        fill_roms(32'h7FFF_0000, 32'h7FFF_0000);
        release_reset();
        step(16);
        checks++;
        if (dut.r_h[0] !== 32'h0) begin
            errors++;
            $display("FAIL sat_h0_before: got %h expected 00000000", dut.r_h[0]);
        end
        step(1);
        checks++;
        if (dut.r_h[0] !== 32'h7FFF_FFFF) begin
            errors++;
            $display("FAIL sat_h0: got %h expected 7fffffff", dut.r_h[0]);
        end
        step(167);
        checks++;
        if (dut.r_h[9] !== 32'h7FFF_FFFF) begin
            errors++;
            $display("FAIL sat_h9: got %h expected 7fffffff", dut.r_h[9]);
        end
        checks++;
        if (dut.r_logit[1] !== 32'h7FFF_FFFF) begin
            errors++;
            $display("FAIL sat_logit1: got %h expected 7fffffff", dut.r_logit[1]);
        end
        // Both logits saturate equal -> pred 0, label nonzero -> wrong.
        checks++;
        if (correct_cnt !== 7'd0) begin
            errors++;
            $display("FAIL sat_tie_count: got %0d expected 0", correct_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_zero_weights();
        test_forward_mixed();
        test_reset_mid_run();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
